// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding an 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_fifo #(
  parameter int CLK_DIV    = 50,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [AW:0] FULL      = {1'b1, {AW{1'b0}}};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t       state;
  logic [15:0]  baud;
  logic [2:0]   bit_idx;
  logic [7:0]   shift;
  logic [7:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]  count;
  logic         bit_end;
  logic         push;
  logic         pop;
`ifdef UART_TX_PARITY_EN
  logic         parity_bit;
`endif

  assign tx_ready   = (count != FULL);
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);
  assign bit_end    = (baud == BAUD_LAST);
  assign push       = tx_valid && tx_ready;
  // The next byte is taken either from idle or straight out of the stop bit, giving gap-free frames.
  assign pop        = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^mem[rd_ptr];
`endif
    end else if ((state == DATA) && bit_end) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      uart_tx <= 1'b1;
    end else begin
      baud <= ((state == IDLE) || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            uart_tx <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            uart_tx <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              uart_tx <= parity_bit;
`else
              state   <= STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              // shift is updated on this same edge, so the next bit is shift[1] now.
              uart_tx <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            uart_tx <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a CLK_DIV=50 instance and a CLK_DIV=2 instance on one clock.
module tb_uart_tx_fifo;

  localparam int DIV = 50;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;
  logic [3:0] fifo_count;

  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2;
  logic       uart_tx2;
  logic       busy2;
  logic [1:0] fifo_count2;

  int checks = 0;
  int failures = 0;
  int busy_cyc = 0;
  int stop_err = 0;
  logic mon_en = 1'b0;
  logic [7:0] rx_q [$];
  logic [7:0] mon_b;

  uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.CLK_DIV(2), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .uart_tx(uart_tx2), .busy(busy2), .fifo_count(fifo_count2)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
  end

  // Independent line receiver used while the bench is busy driving the input side.
  always begin
    @(posedge clk); #1;
    if (mon_en && uart_tx === 1'b0) begin
      repeat (DIV / 2) begin @(posedge clk); #1; end
      for (int k = 0; k < 8; k++) begin
        repeat (DIV) begin @(posedge clk); #1; end
        mon_b[k] = uart_tx;
      end
      repeat ((FB - 9) * DIV) begin @(posedge clk); #1; end
      if (uart_tx !== 1'b1) stop_err = stop_err + 1;
      rx_q.push_back(mon_b);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic expbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at offset o0 cycles into a frame whose start bit began at offset 0.
  task automatic frame(input string tag, input logic [7:0] exp_b, input int div, input bit sel,
                       input int o0, output logic [7:0] rx, output logic b9);
    int bad;
    logic ln, bz;
    bad = 0;
    rx = 8'h00;
    b9 = 1'bx;
    for (int o = o0; o < FB * div; o++) begin
      ln = sel ? uart_tx2 : uart_tx;
      bz = sel ? busy2 : busy;
      if (ln !== expbit(exp_b, o / div) || bz !== 1'b1) bad++;
      if (o % div == div / 2) begin
        if (o / div >= 1 && o / div <= 8) rx[o / div - 1] = ln;
        if (o / div == 9) b9 = ln;
      end
      step();
    end
    check({tag, "_shape"}, 32'(bad), 0);
    check({tag, "_data"}, 32'(rx), 32'(exp_b));
  endtask

  initial begin
    logic [7:0] rx;
    logic       b9;
    logic [7:0] burst [8];
    logic [7:0] bp [10];
    int bad, max_cnt, ready_low, busy_ref, k, cyc, acc_cyc, n;
    logic acc, saw_full;
    int ready_bad;

    burst = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    bp    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hA5};

    repeat (3) step();
    check("rst_line", 32'(uart_tx), 1);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_line2", 32'(uart_tx2), 1);
    check("rst_ready2", 32'(tx_ready2), 1);
    reset = 1'b1;
    repeat (2) step();

    // Single byte 0x2D
    tx_data = 8'h2D; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("s_line_at_accept", 32'(uart_tx), 1);
    check("s_count_at_accept", 32'(fifo_count), 1);
    check("s_busy_at_accept", 32'(busy), 1);
    step();
    check("s_start_fall", 32'(uart_tx), 0);
    check("s_count_after_pop", 32'(fifo_count), 0);
    frame("s", 8'h2D, DIV, 1'b0, 0, rx, b9);
    check("s_bit9", 32'(b9), 32'(expbit(8'h2D, 9)));
    check("s_busy_fall", 32'(busy), 0);
    check("s_line_idle", 32'(uart_tx), 1);
    repeat (5) step();

    // Burst of 8 bytes on consecutive cycles
    max_cnt = 0; ready_low = 0; busy_ref = 0;
    for (int i = 0; i < 8; i++) begin
      tx_data = burst[i]; tx_valid = 1'b1;
      if (tx_ready !== 1'b1) ready_low++;
      step();
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (i == 1) begin
        busy_ref = busy_cyc;
        check("b_start_fall", 32'(uart_tx), 0);
      end
    end
    tx_valid = 1'b0;
    check("b_ready_high", 32'(ready_low), 0);
    check("b_peak_count", 32'(max_cnt), 7);
    frame("b0", burst[0], DIV, 1'b0, 6, rx, b9);
    for (int i = 1; i < 8; i++) frame($sformatf("b%0d", i), burst[i], DIV, 1'b0, 0, rx, b9);
    check("b_busy_fall", 32'(busy), 0);
    check("b_busy_time", 32'(busy_cyc - busy_ref), 32'(8 * FB * DIV));
    repeat (5) step();

    // Backpressure: 10 bytes with tx_valid held high
    mon_en = 1'b1;
    k = 0; cyc = 0; acc_cyc = 0; saw_full = 1'b0; ready_bad = 0;
    tx_data = bp[0]; tx_valid = 1'b1;
    while (k < 10 && cyc < 2000) begin
      acc = tx_ready;
      if (fifo_count == 4'd8) begin
        saw_full = 1'b1;
        if (tx_ready !== 1'b0) ready_bad++;
      end
      step();
      cyc++;
      if (acc) begin
        k++;
        if (k == 10) acc_cyc = cyc;
        else tx_data = bp[k];
      end
    end
    tx_valid = 1'b0;
    check("bp_all_accepted", 32'(k), 10);
    check("bp_saw_full", 32'(saw_full), 1);
    check("bp_ready_low_when_full", 32'(ready_bad), 0);
    check("bp_last_accept_cycle", 32'(acc_cyc), 32'(2 + FB * DIV + 1));
    n = 0;
    while ((rx_q.size() < 10 || busy !== 1'b0) && n < 7000) begin
      step();
      n++;
    end
    check("bp_rx_count", 32'(rx_q.size()), 10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++)
      check($sformatf("bp_byte%0d", i), 32'(rx_q[i]), 32'(bp[i]));
    check("bp_stop_bits", 32'(stop_err), 0);
    mon_en = 1'b0;
    repeat (5) step();

`ifdef UART_TX_PARITY_EN
    tx_data = 8'h07; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    check("p07_start_fall", 32'(uart_tx), 0);
    frame("p07", 8'h07, DIV, 1'b0, 0, rx, b9);
    check("p07_parity", 32'(b9), 1);
    check("p07_busy_fall", 32'(busy), 0);
    tx_data = 8'h03; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    check("p03_start_fall", 32'(uart_tx), 0);
    frame("p03", 8'h03, DIV, 1'b0, 0, rx, b9);
    check("p03_parity", 32'(b9), 0);
    check("p03_busy_fall", 32'(busy), 0);
    repeat (5) step();
`endif

    // Minimum divider on the second instance
    tx_data2 = 8'h55; tx_valid2 = 1'b1;
    step();
    tx_valid2 = 1'b0;
    step();
    check("m_start_fall", 32'(uart_tx2), 0);
    frame("m", 8'h55, 2, 1'b1, 0, rx, b9);
    check("m_busy_fall", 32'(busy2), 0);
    check("m_count", 32'(fifo_count2), 0);
    check("m_line_idle", 32'(uart_tx2), 1);
    repeat (5) step();

    // Reset during data bit 3 of 0xA5 with 0x3C still queued
    tx_data = 8'hA5; tx_valid = 1'b1;
    step();
    tx_data = 8'h3C;
    step();
    tx_valid = 1'b0;
    check("r_start_fall", 32'(uart_tx), 0);
    check("r_count_queued", 32'(fifo_count), 1);
    repeat (4 * DIV + DIV / 2) step();
    check("r_bit3_low", 32'(uart_tx), 0);
    #4 reset = 1'b0;
    #1;
    check("r_async_line", 32'(uart_tx), 1);
    check("r_async_count", 32'(fifo_count), 0);
    check("r_async_busy", 32'(busy), 0);
    check("r_async_ready", 32'(tx_ready), 1);
    repeat (2) step();
    reset = 1'b1;
    bad = 0;
    repeat (1000) begin
      step();
      if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0) bad++;
    end
    check("r_quiet_after_release", 32'(bad), 0);
    tx_data = 8'h5A; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    check("r_restart_fall", 32'(uart_tx), 0);
    frame("r", 8'h5A, DIV, 1'b0, 0, rx, b9);
    check("r_busy_fall", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
